mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The module SHALL have parameter size, default 32: responder memory depth in words.
REQ-002 The module SHALL have parameter data_width, default 32: memory word width.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: copy request, sampled only in IDLE.
REQ-006 The module SHALL have port src_addr, input, 32 bits: byte address of the first source word.
REQ-007 The module SHALL have port dst_addr, input, 32 bits: byte address of the first destination word.
REQ-008 The module SHALL have port word_count, input, 16 bits: number of words to copy.
REQ-009 The module SHALL have port abort, input, 1 bit: cancels an in-progress copy.
REQ-010 The module SHALL have port busy, output, 1 bit: high in READ and WRITE.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The module SHALL have port error, output, 1 bit: sticky request-rejected flag.
REQ-013 The module SHALL have port mem_address, output, 32 bits: byte address to memory; memory indexes words by address>>2.
REQ-014 The module SHALL have port mem_data_write, output, data_width bits: write data to memory.
REQ-015 The module SHALL have port mem_write_en, output, 1 bit: memory write strobe; memory commits on the clk edge.
REQ-016 The module SHALL have port mem_read_en, output, 1 bit: memory read enable.
REQ-017 The module SHALL have port mem_data_in, input, data_width bits: memory read data, combinational from mem_address.

Function
REQ-018 The state machine SHALL have exactly five states: IDLE, READ, WRITE, DONE, ERR.
REQ-019 In IDLE, start=1 with invalid parameters SHALL cause a transition to ERR; parameters are invalid when src_addr[1:0]!=0, dst_addr[1:0]!=0, src_addr/4+word_count>size, or dst_addr/4+word_count>size (bounds computed at 33 bits, no wrap).
REQ-020 In IDLE, start=1 with valid parameters and word_count=0 SHALL cause a transition to DONE with no memory access.
REQ-021 In IDLE, start=1 with otherwise valid parameters SHALL latch src_ptr, dst_ptr and remaining from the inputs and transition to READ.
REQ-022 In READ, the module SHALL drive mem_read_en=1 and mem_address=src_ptr, capture mem_data_in into buf at the edge, and transition to WRITE.
REQ-023 In WRITE, the module SHALL drive mem_write_en=1, mem_address=dst_ptr and mem_data_write=buf; at the edge it SHALL add 4 to src_ptr and dst_ptr and decrement remaining.
REQ-024 From WRITE, the next state SHALL be DONE when remaining was 1, otherwise READ.
REQ-025 Each word SHALL take 2 cycles, so an N-word copy takes 2N+1 cycles from the start edge through the DONE cycle.
REQ-026 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-027 In ERR, error SHALL be set, the next state SHALL be IDLE, and error SHALL stay high until the next accepted valid start or reset.
REQ-028 When abort=1 in READ or WRITE, the next state SHALL be IDLE with no done pulse; a write strobed in that WRITE cycle still commits.
REQ-029 When abort and the final WRITE coincide, abort SHALL win: no done pulse.
REQ-030 start SHALL be ignored outside IDLE, and input changes after acceptance SHALL have no effect.
REQ-031 mem_read_en and mem_write_en SHALL never be high together, and both SHALL be 0 outside READ and WRITE.
REQ-032 Outside the state that drives them, mem_address and mem_data_write SHALL be 0.
REQ-033 Overlapping regions SHALL be copied forward, ascending addresses, one word at a time; no overlap correction.

Reset
REQ-034 reset=1 SHALL immediately force IDLE, regardless of clk.
REQ-035 Under reset, busy, done, error, mem_read_en, mem_write_en, mem_address, mem_data_write, src_ptr, dst_ptr, remaining and buf SHALL all be 0.
REQ-036 Reset mid-copy SHALL abandon the transfer with no done pulse; words already written stay written.

Verification
REQ-037 The bench SHALL check: memory words 0..2 = 3,5,8; start with src=0, dst=0x40, count=3 -> words 16..18 = 3,5,8, done exactly at cycle 7 after start, busy high for 6 cycles.
REQ-038 The bench SHALL check: start with src=0x02 -> ERR, error=1, no mem strobes; then a valid start clears error.
REQ-039 The bench SHALL check: src=0x70, count=5, size=32 (28+5>32) -> error=1, no access.
REQ-040 The bench SHALL check: count=0 -> done one cycle after start, busy never high.
REQ-041 The bench SHALL check: abort asserted in the second WRITE of a 4-word copy -> exactly 2 words written, no done, IDLE next cycle.
REQ-042 The bench SHALL check: reset asserted asynchronously mid-READ -> all outputs 0 before the next clk edge, and a fresh start completes correctly.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: validates a copy request, then alternates a READ
// cycle and a WRITE cycle per word, ending with a one-cycle done pulse.
module mem_copy_engine #(
  parameter int unsigned size       = 32,
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           src_addr,
  input  logic [31:0]           dst_addr,
  input  logic [15:0]           word_count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           mem_address,
  output logic [data_width-1:0] mem_data_write,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  input  logic [data_width-1:0] mem_data_in
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StDone,
    StErr
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [31:0]           r_src_ptr;
  logic [31:0]           r_dst_ptr;
  logic [15:0]           r_remaining;
  logic [data_width-1:0] r_buf;
  logic                  r_error;

  logic [32:0] w_src_end;
  logic [32:0] w_dst_end;
  logic        w_valid;

  // End-of-region word indices at 33 bits so large addresses cannot wrap into range.
  assign w_src_end = {3'b000, src_addr[31:2]} + {17'd0, word_count};
  assign w_dst_end = {3'b000, dst_addr[31:2]} + {17'd0, word_count};
  assign w_valid   = (src_addr[1:0] == 2'b00) && (dst_addr[1:0] == 2'b00) &&
                     (w_src_end <= 33'(size)) && (w_dst_end <= 33'(size));

  always_comb begin
    w_state_next   = r_state;
    busy           = 1'b0;
    done           = 1'b0;
    mem_address    = 32'd0;
    mem_data_write = '0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          if (!w_valid)                 w_state_next = StErr;
          else if (word_count == 16'd0) w_state_next = StDone;
          else                          w_state_next = StRead;
        end
      end
      StRead: begin
        busy         = 1'b1;
        mem_read_en  = 1'b1;
        mem_address  = r_src_ptr;
        w_state_next = abort ? StIdle : StWrite;
      end
      StWrite: begin
        busy           = 1'b1;
        mem_write_en   = 1'b1;
        mem_address    = r_dst_ptr;
        mem_data_write = r_buf;
        if (abort)                     w_state_next = StIdle;
        else if (r_remaining == 16'd1) w_state_next = StDone;
        else                           w_state_next = StRead;
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      StErr: begin
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign error = r_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_src_ptr   <= 32'd0;
      r_dst_ptr   <= 32'd0;
      r_remaining <= 16'd0;
      r_buf       <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (w_valid) begin
              r_error     <= 1'b0;
              r_src_ptr   <= src_addr;
              r_dst_ptr   <= dst_addr;
              r_remaining <= word_count;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        StRead: r_buf <= mem_data_in;
        StWrite: begin
          r_src_ptr   <= r_src_ptr + 32'd4;
          r_dst_ptr   <= r_dst_ptr + 32'd4;
          r_remaining <= r_remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 32-word behavioural memory responder.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] word_count;
  logic        abort;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] mem_address;
  logic [31:0] mem_data_write;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_data_in;

  logic [31:0] mem [0:31];
  logic        ld_en;
  logic [4:0]  ld_a;
  logic [31:0] ld_d;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(
    .size      (32),
    .data_width(32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .word_count    (word_count),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .mem_address   (mem_address),
    .mem_data_write(mem_data_write),
    .mem_write_en  (mem_write_en),
    .mem_read_en   (mem_read_en),
    .mem_data_in   (mem_data_in)
  );

  assign mem_data_in = mem[mem_address[6:2]];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[6:2]] <= mem_data_write;
    else if (ld_en)   mem[ld_a] <= ld_d;
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (mem_read_en) rd_cnt++;
    if (mem_write_en) wr_cnt++;
    if (mem_read_en && mem_write_en) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_a  = 5'(a);
    ld_d  = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Returns at the negedge of cycle 1 after the accepting edge; inputs are scrambled then.
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] c);
    @(negedge clk);
    src_addr   = s;
    dst_addr   = d;
    word_count = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    src_addr   = 32'hFFFF_FFF3;
    dst_addr   = 32'h0000_0005;
    word_count = 16'hFFFF;
  endtask

  task automatic find_done(input int first, output int fd);
    fd = 0;
    for (int i = first; i <= first + 30; i++) begin
      if (done && fd == 0) fd = i;
      @(negedge clk);
    end
  endtask

  initial begin
    int b_busy, b_done, b_rd, b_wr, fd;
    reset = 1'b1; start = 1'b0; abort = 1'b0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
    src_addr = '0; dst_addr = '0; word_count = '0;
    load(0, 32'd3); load(1, 32'd5); load(2, 32'd8); load(3, 32'd13);
    for (int i = 16; i < 32; i++) load(i, 32'hAA);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rd", mem_read_en, 0);
    chk("rst_wr", mem_write_en, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_data_write, 0);
    @(negedge clk);
    reset = 1'b0;

    // 3-word copy 0x00 -> 0x40
    b_busy = busy_cnt; b_done = done_cnt; b_rd = rd_cnt; b_wr = wr_cnt;
    start_copy(32'h0, 32'h40, 16'd3);
    chk("c1_rd_en", mem_read_en, 1);
    chk("c1_rd_addr", mem_address, 32'h0);
    @(negedge clk);
    chk("c1_wr_en", mem_write_en, 1);
    chk("c1_wr_addr", mem_address, 32'h40);
    chk("c1_wr_data", mem_data_write, 32'd3);
    find_done(2, fd);
    chk("c1_done_cycle", fd, 7);
    chk("c1_busy_cycles", busy_cnt - b_busy, 6);
    chk("c1_done_pulses", done_cnt - b_done, 1);
    chk("c1_reads", rd_cnt - b_rd, 3);
    chk("c1_writes", wr_cnt - b_wr, 3);
    chk("c1_w16", mem[16], 32'd3);
    chk("c1_w17", mem[17], 32'd5);
    chk("c1_w18", mem[18], 32'd8);
    chk("c1_w19", mem[19], 32'hAA);

    // misaligned source -> ERR, then a valid start clears error
    b_rd = rd_cnt; b_wr = wr_cnt;
    start_copy(32'h2, 32'h40, 16'd1);
    chk("mis_error", error, 1);
    chk("mis_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("mis_sticky", error, 1);
    chk("mis_strobes", (rd_cnt - b_rd) + (wr_cnt - b_wr), 0);
    start_copy(32'h0, 32'h50, 16'd1);
    chk("mis_cleared", error, 0);
    find_done(1, fd);
    chk("mis_fix_done", fd, 3);
    chk("mis_fix_w20", mem[20], 32'd3);

    // out-of-bounds: 28+5 > 32
    b_rd = rd_cnt; b_wr = wr_cnt;
    start_copy(32'h70, 32'h0, 16'd5);
    chk("oob_error", error, 1);
    repeat (3) @(negedge clk);
    chk("oob_strobes", (rd_cnt - b_rd) + (wr_cnt - b_wr), 0);

    // exactly at the bound: 27+5 == 32 is accepted
    start_copy(32'h6C, 32'h6C, 16'd5);
    chk("edge_error", error, 0);
    find_done(1, fd);
    chk("edge_done", fd, 11);

    // zero-length copy
    b_busy = busy_cnt; b_rd = rd_cnt; b_wr = wr_cnt;
    start_copy(32'h0, 32'h0, 16'd0);
    chk("zero_done", done, 1);
    repeat (3) @(negedge clk);
    chk("zero_busy", busy_cnt - b_busy, 0);
    chk("zero_strobes", (rd_cnt - b_rd) + (wr_cnt - b_wr), 0);

    // abort in the second WRITE of a 4-word copy
    b_done = done_cnt; b_wr = wr_cnt;
    start_copy(32'h0, 32'h60, 16'd4);
    repeat (3) @(negedge clk);
    chk("ab_in_write", mem_write_en, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_idle_busy", busy, 0);
    chk("ab_idle_rd", mem_read_en, 0);
    repeat (12) @(negedge clk);
    chk("ab_no_done", done_cnt - b_done, 0);
    chk("ab_writes", wr_cnt - b_wr, 2);
    chk("ab_w24", mem[24], 32'd3);
    chk("ab_w25", mem[25], 32'd5);
    chk("ab_w26", mem[26], 32'hAA);

    // asynchronous reset mid-READ
    b_done = done_cnt;
    start_copy(32'h0, 32'h70, 16'd3);
    chk("ar_in_read", mem_read_en, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_rd", mem_read_en, 0);
    chk("ar_addr", mem_address, 0);
    chk("ar_wr", mem_write_en, 0);
    chk("ar_wdata", mem_data_write, 0);
    chk("ar_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("ar_no_done", done_cnt - b_done, 0);
    chk("ar_w28_kept", mem[28], 32'hAA);
    start_copy(32'h0, 32'h70, 16'd3);
    find_done(1, fd);
    chk("ar_re_done", fd, 7);
    chk("ar_w28", mem[28], 32'd3);
    chk("ar_w29", mem[29], 32'd5);
    chk("ar_w30", mem[30], 32'd8);

    chk("never_both_strobes", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
